mux_scan_sel: RTL and testbench
===============================

# mux_scan_sel

Parametrised N-channel, W-bit registered multiplexer for the DE-board lab tops. It drives board LEDs from one of N packed input channels. The channel is chosen at run time by debounced NEXT/PREV push-buttons or by an automatic scan timer. A HOLD input freezes both the selection and the output. It replaces the fixed, compile-time exercise selection in the lab top-level with one runtime-selectable, clocked block.

## Interface
- W, 4: data width per channel.
- N, 4: number of channels, N ≥ 2; need not be a power of two.
- SELW, 2: select width; must satisfy 2^SELW ≥ N.
- DEB_CYC, 500000: consecutive stable cycles needed to accept a button level change; ≥ 2.
- SCAN_DIV, 50000000: auto-scan period in clock cycles; ≥ 2.

- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DATA_IN  in  N*W  packed channels; channel i = DATA_IN[i*W +: W].
- KEY_NEXT  in  1  raw push-button, active-low (pressed = 0); asynchronous.
- KEY_PREV  in  1  raw push-button, active-low; asynchronous.
- MODE_AUTO  in  1  slide switch: 1 = auto-scan, 0 = manual; asynchronous.
- HOLD  in  1  slide switch: 1 = freeze; asynchronous.
- DATA_OUT  out  W  registered selected channel.
- SEL  out  SELW  current channel index.
- STROBE  out  1  one-cycle pulse, high in the first cycle a new SEL value is visible.

## Operation
- Synchronisation: KEY_NEXT, KEY_PREV, MODE_AUTO and HOLD each pass through a 2-flop synchroniser.
- Debounce, per key:
  - State deb is reset to 1 (released).
  - Counter cnt increments while the synchronised level differs from deb; it clears when they match.
  - When cnt reaches DEB_CYC-1 with the level still differing, deb takes the new level and cnt clears.
- Press event: deb goes 1→0, registered to give a one-cycle pulse. Release generates nothing.
- Step resolution, evaluated each cycle with HOLD synchronised = 0:
  - next only: SEL ← (SEL == N-1) ? 0 : SEL+1.
  - prev only: SEL ← (SEL == 0) ? N-1 : SEL-1.
  - next and prev in the same cycle: cancel. No step, no STROBE, scan counter unaffected.
- Auto scan:
  - Counter scnt is held at 0 while MODE_AUTO = 0.
  - In auto mode it counts 0..SCAN_DIV-1. At terminal count it produces a next-step and clears.
  - A key step in auto mode is applied and also clears scnt.
  - A key step coincident with a terminal count produces a single step, not two.
- HOLD = 1:
  - SEL, DATA_OUT and scnt are frozen and STROBE is 0.
  - Press events occurring during HOLD are discarded.
  - Debouncers keep running, so no spurious press follows HOLD release.
- Output: DATA_OUT ← channel[SEL] every cycle while not held. SEL values ≥ N are unreachable.
- STROBE is registered alongside the SEL update.
- Reset (asynchronous assert, mid-operation included) forces:
  - SEL = 0, DATA_OUT = 0, STROBE = 0.
  - scnt = 0, all debounce counters = 0, deb = 1, synchronisers = 1 for keys and 0 for switches.
- A key held low through reset release is accepted as exactly one press after debounce.

## Timing
- Reset values: DATA_OUT = 0, SEL = 0, STROBE = 0.
- First valid DATA_OUT = channel 0, one cycle after reset release.
- Key latency: raw key sampled low at edge k and held stable gives:
  - SEL updated and STROBE high at edge k + DEB_CYC + 3.
  - DATA_OUT showing the new channel at edge k + DEB_CYC + 4.
- Pulses shorter than DEB_CYC cycles after synchronisation are rejected.
- Auto-scan SEL steps are exactly SCAN_DIV cycles apart. The first step comes SCAN_DIV cycles after synchronised MODE_AUTO rises.
- DATA_IN → DATA_OUT latency is 1 cycle with SEL constant.
- Mode and HOLD changes take effect 2 cycles after the raw edge.

## Test plan
Common parameters: W=4, N=3, SELW=2, DEB_CYC=4, SCAN_DIV=8, DATA_IN = {4'hC, 4'hB, 4'hA}.

- Reset then release, all inputs idle → SEL=0, STROBE=0, DATA_OUT=0 in the release cycle, then 4'hA.
- Three clean KEY_NEXT presses of 10 cycles each, spaced 20 cycles apart:
  - SEL goes 1, 2, 0, each change exactly 7 cycles after the press, with one STROBE pulse each.
  - DATA_OUT follows B, C, A one cycle later.
- KEY_NEXT glitch low for 3 cycles → no change. Then KEY_PREV press from SEL=0 → SEL=2, DATA_OUT=4'hC.
- MODE_AUTO=1:
  - SEL steps 0→1→2→0 every 8 cycles.
  - HOLD=1 for 20 cycles while DATA_IN changes → SEL, DATA_OUT and STROBE frozen.
  - After HOLD release, the next step arrives after the remaining scnt count.
- Simultaneous events:
  - NEXT press event aligned with a scan terminal count → a single step; the next auto step comes 8 cycles later.
  - NEXT and PREV events in the same cycle → no step, no STROBE.
- Reset asserted mid-scan at SEL=2 with KEY_NEXT held low:
  - Outputs clear immediately, without a clock.
  - After release and debounce, exactly one step to SEL=1.

Source files
------------

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: runtime-selectable registered N:1 multiplexer for the lab board LEDs.
// The channel is stepped by debounced NEXT/PREV keys or by an auto-scan timer; HOLD freezes it.
module mux_scan_sel #(
    parameter int W        = 4,
    parameter int N        = 4,
    parameter int SELW     = 2,
    parameter int DEB_CYC  = 500000,
    parameter int SCAN_DIV = 50000000
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic [N*W-1:0]  DATA_IN,
    input  logic            KEY_NEXT,
    input  logic            KEY_PREV,
    input  logic            MODE_AUTO,
    input  logic            HOLD,
    output logic [W-1:0]    DATA_OUT,
    output logic [SELW-1:0] SEL,
    output logic            STROBE
);
    localparam int DW = $clog2(DEB_CYC);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0]   SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(N - 1);

    // Key vectors: bit 0 = NEXT, bit 1 = PREV. Switch vectors: bit 0 = MODE_AUTO, bit 1 = HOLD.
    logic [1:0]    key_s1, key_s2;
    logic [1:0]    sw_s1, sw_s2;
    logic [1:0]    deb, deb_d, press;
    logic [DW-1:0] cnt [2];
    logic [SW-1:0] scnt;

    logic            hold_s, auto_s;
    logic            ev_next, ev_prev, tc;
    logic            step_next, step_prev;
    logic [SELW-1:0] sel_inc, sel_dec;
    logic [W-1:0]    chan;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            key_s1 <= {KEY_PREV, KEY_NEXT};
            key_s2 <= key_s1;
            sw_s1  <= {HOLD, MODE_AUTO};
            sw_s2  <= sw_s1;
        end
    end

    // A new key level is accepted only after DEB_CYC consecutive differing samples.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb   <= 2'b11;
            deb_d <= 2'b11;
            press <= 2'b00;
            for (int k = 0; k < 2; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] != deb[k]) begin
                    if (cnt[k] == DEB_LAST) begin
                        deb[k] <= key_s2[k];
                        cnt[k] <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + DW'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
            deb_d <= deb;
            press <= deb_d & ~deb;
        end
    end

    assign hold_s = sw_s2[1];
    assign auto_s = sw_s2[0];

    // Opposite presses in the same cycle cancel; a lone key step absorbs a coincident scan step.
    always_comb begin
        ev_next   = press[0] & ~press[1] & ~hold_s;
        ev_prev   = press[1] & ~press[0] & ~hold_s;
        tc        = auto_s & ~hold_s & (scnt == SCAN_LAST);
        step_next = ev_next | (tc & ~ev_prev);
        step_prev = ev_prev;
        sel_inc   = (SEL == SEL_LAST) ? '0 : SEL + SELW'(1);
        sel_dec   = (SEL == '0) ? SEL_LAST : SEL - SELW'(1);
        chan      = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL == SELW'(i)) chan = DATA_IN[i*W +: W];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            SEL      <= '0;
            STROBE   <= 1'b0;
            DATA_OUT <= '0;
            scnt     <= '0;
        end else if (hold_s) begin
            STROBE <= 1'b0;
        end else begin
            DATA_OUT <= chan;
            STROBE   <= step_next | step_prev;
            if (step_next) begin
                SEL <= sel_inc;
            end else if (step_prev) begin
                SEL <= sel_dec;
            end
            if (!auto_s || step_next || step_prev) begin
                scnt <= '0;
            end else begin
                scnt <= scnt + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel: directed scenarios plus random stimulus, all
// compared every cycle against a behavioural model of the selection rules.
module tb_mux_scan_sel;
    localparam int W    = 4;
    localparam int N    = 3;
    localparam int SELW = 2;
    localparam int DEB  = 4;
    localparam int SDIV = 8;

    logic            CLOCK_50;
    logic            RESET_N;
    logic [N*W-1:0]  DATA_IN;
    logic            KEY_NEXT, KEY_PREV, MODE_AUTO, HOLD;
    logic [W-1:0]    DATA_OUT;
    logic [SELW-1:0] SEL;
    logic            STROBE;

    int n_checks = 0;
    int n_pass   = 0;

    mux_scan_sel #(
        .W(W), .N(N), .SELW(SELW), .DEB_CYC(DEB), .SCAN_DIV(SDIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .DATA_IN  (DATA_IN),
        .KEY_NEXT (KEY_NEXT),
        .KEY_PREV (KEY_PREV),
        .MODE_AUTO(MODE_AUTO),
        .HOLD     (HOLD),
        .DATA_OUT (DATA_OUT),
        .SEL      (SEL),
        .STROBE   (STROBE)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: raw levels reach the logic two edges late; a key level is accepted
    // when the last DEB synced samples all differ from it; an accepted press acts two edges later.
    int       m_sel, m_out, m_strobe, m_phase, old_sel;
    logic [1:0] nh, ph, mh, hh, nf, pf;
    bit       n_deb, p_deb, ns, ps, ms, hs, n_fell, p_fell, kn, kp, tc;
    bit       n_win[$], p_win[$];

    function automatic bit all_differ(input bit q[$], input bit d);
        if (q.size() < DEB) return 1'b0;
        foreach (q[i]) if (q[i] == d) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_out = 0; m_strobe = 0; m_phase = 0;
        nh = 2'b11; ph = 2'b11; mh = 2'b00; hh = 2'b00;
        nf = 2'b00; pf = 2'b00;
        n_deb = 1'b1; p_deb = 1'b1;
        n_win.delete(); p_win.delete();
        for (int i = 0; i < DEB; i++) begin
            n_win.push_back(1'b1);
            p_win.push_back(1'b1);
        end
    endtask

    initial model_reset();

    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            model_reset();
        end else begin
            ns = nh[1]; ps = ph[1]; ms = mh[1]; hs = hh[1];
            n_win.push_back(ns); if (n_win.size() > DEB) void'(n_win.pop_front());
            p_win.push_back(ps); if (p_win.size() > DEB) void'(p_win.pop_front());
            n_fell = 1'b0; p_fell = 1'b0;
            if (all_differ(n_win, n_deb)) begin n_fell = n_deb; n_deb = ns; end
            if (all_differ(p_win, p_deb)) begin p_fell = p_deb; p_deb = ps; end
            kn = nf[1] && !pf[1] && !hs;
            kp = pf[1] && !nf[1] && !hs;
            nf = {nf[0], n_fell};
            pf = {pf[0], p_fell};
            old_sel = m_sel;
            if (hs) begin
                m_strobe = 0;
            end else begin
                tc = ms && (m_phase == SDIV - 1);
                if (kn || (tc && !kp)) m_sel = (m_sel + 1) % N;
                else if (kp) m_sel = (m_sel + N - 1) % N;
                m_strobe = (kn || kp || tc) ? 1 : 0;
                if (!ms || kn || kp || tc) m_phase = 0;
                else m_phase = m_phase + 1;
                m_out = int'((DATA_IN >> (old_sel * W)) & 12'hF);
            end
            nh = {nh[0], KEY_NEXT};
            ph = {ph[0], KEY_PREV};
            mh = {mh[0], MODE_AUTO};
            hh = {hh[0], HOLD};
        end
        #1;
        check("model_sel", int'(SEL), m_sel);
        check("model_data", int'(DATA_OUT), m_out);
        check("model_strobe", int'(STROBE), m_strobe);
    end

    // Press a key at a negedge and pin the step to exactly DEB+3 edges after it was sampled.
    task automatic press_check(input bit is_next, input int prev_sel, input int exp_sel,
                               input int exp_data);
        @(negedge CLOCK_50);
        if (is_next) KEY_NEXT = 1'b0; else KEY_PREV = 1'b0;
        @(posedge CLOCK_50);
        repeat (DEB + 2) @(posedge CLOCK_50);
        #1 check("key_pre_step_sel", int'(SEL), prev_sel);
        @(posedge CLOCK_50);
        #1 check("key_step_sel", int'(SEL), exp_sel);
        check("key_step_strobe", int'(STROBE), 1);
        @(posedge CLOCK_50);
        #1 check("key_data", int'(DATA_OUT), exp_data);
        check("key_strobe_low", int'(STROBE), 0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY_NEXT = 1'b1; KEY_PREV = 1'b1;
        repeat (20) @(negedge CLOCK_50);
    endtask

    int  s0;
    int  waited;

    initial begin
        RESET_N = 1'b0; KEY_NEXT = 1'b1; KEY_PREV = 1'b1;
        MODE_AUTO = 1'b0; HOLD = 1'b0; DATA_IN = 12'hCBA;
        repeat (3) @(negedge CLOCK_50);
        check("rst_sel", int'(SEL), 0);
        check("rst_data", int'(DATA_OUT), 0);
        check("rst_strobe", int'(STROBE), 0);
        RESET_N = 1'b1;
        #1 check("release_data", int'(DATA_OUT), 0);
        @(posedge CLOCK_50);
        #1 check("first_data", int'(DATA_OUT), 4'hA);

        press_check(1'b1, 0, 1, 4'hB);
        press_check(1'b1, 1, 2, 4'hC);
        press_check(1'b1, 2, 0, 4'hA);

        @(negedge CLOCK_50) KEY_NEXT = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        KEY_NEXT = 1'b1;
        repeat (15) @(negedge CLOCK_50);
        check("glitch_sel", int'(SEL), 0);
        press_check(1'b0, 0, 2, 4'hC);

        // Auto scan: sync rises one edge after the raw sample, first step SDIV edges later.
        @(negedge CLOCK_50) MODE_AUTO = 1'b1;
        @(posedge CLOCK_50);
        repeat (SDIV) @(posedge CLOCK_50);
        #1 check("auto_pre_sel", int'(SEL), 2);
        @(posedge CLOCK_50);
        #1 check("auto_step_sel", int'(SEL), 0);
        check("auto_step_strobe", int'(STROBE), 1);
        repeat (SDIV - 1) @(posedge CLOCK_50);
        #1 check("auto_gap_sel", int'(SEL), 0);
        @(posedge CLOCK_50);
        #1 check("auto_step2_sel", int'(SEL), 1);

        @(negedge CLOCK_50) HOLD = 1'b1;
        repeat (20) begin
            @(negedge CLOCK_50);
            DATA_IN = 12'($urandom);
        end
        HOLD = 1'b0;
        DATA_IN = 12'hCBA;
        repeat (30) @(negedge CLOCK_50);

        // Key press timed so its step lands on a scan terminal count.
        waited = 0;
        while (m_phase != 0 && waited < 20) begin
            @(negedge CLOCK_50);
            waited++;
        end
        check("align_wait_ok", (waited < 20) ? 1 : 0, 1);
        s0 = m_sel;
        KEY_NEXT = 1'b0;
        @(posedge CLOCK_50);
        repeat (DEB + 2) @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 check("coinc_sel", int'(SEL), (s0 + 1) % N);
        check("coinc_strobe", int'(STROBE), 1);
        for (int i = 0; i < SDIV - 1; i++) begin
            @(posedge CLOCK_50);
            #1 check("coinc_gap_strobe", int'(STROBE), 0);
        end
        @(posedge CLOCK_50);
        #1 check("coinc_next_auto", int'(STROBE), 1);
        check("coinc_next_sel", int'(SEL), (s0 + 2) % N);
        @(negedge CLOCK_50) KEY_NEXT = 1'b1;

        @(negedge CLOCK_50) MODE_AUTO = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        s0 = int'(m_sel);
        KEY_NEXT = 1'b0; KEY_PREV = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLOCK_50);
            #1 check("cancel_strobe", int'(STROBE), 0);
        end
        check("cancel_sel", int'(SEL), s0);
        @(negedge CLOCK_50);
        KEY_NEXT = 1'b1; KEY_PREV = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Reset mid-scan at SEL=2 with NEXT held low through the reset.
        MODE_AUTO = 1'b1;
        waited = 0;
        while (m_sel != 2 && waited < 60) begin
            @(negedge CLOCK_50);
            waited++;
        end
        check("sel2_wait_ok", (waited < 60) ? 1 : 0, 1);
        check("pre_reset_sel", int'(SEL), 2);
        KEY_NEXT = 1'b0;
        #1 RESET_N = 1'b0;
        #1 check("async_rst_sel", int'(SEL), 0);
        check("async_rst_data", int'(DATA_OUT), 0);
        check("async_rst_strobe", int'(STROBE), 0);
        MODE_AUTO = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        check("held_key_one_step", int'(SEL), 1);
        KEY_NEXT = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        for (int c = 0; c < 800; c++) begin
            @(negedge CLOCK_50);
            if ($urandom_range(0, 5) == 0) KEY_NEXT = ~KEY_NEXT;
            if ($urandom_range(0, 5) == 0) KEY_PREV = ~KEY_PREV;
            if ($urandom_range(0, 39) == 0) MODE_AUTO = ~MODE_AUTO;
            if ($urandom_range(0, 49) == 0) HOLD = ~HOLD;
            if ($urandom_range(0, 9) == 0) DATA_IN = 12'($urandom);
        end
        repeat (3) @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
